// File: rtl/intc_pkg.sv
// Shared constants and types for the four-line interrupt controller.
package intc_pkg;
    localparam int NUM_IRQ = 4;

    // Register offsets as decoded from input_addr[3:2]
    localparam logic [1:0] STATUS_OFS  = 2'd0;
    localparam logic [1:0] PENDING_OFS = 2'd1;
    localparam logic [1:0] MASK_OFS    = 2'd2;

    typedef logic [1:0] irq_idx_t;
endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority 4-to-2 encoder, highest index wins; idx is 0 when nothing requests.
// Latency: combinational. Backpressure: none.
import intc_pkg::*;

module intc_prio_enc (
    input  logic [NUM_IRQ-1:0] req,
    output irq_idx_t           idx,
    output logic               vld
);
    always_comb begin
        idx = 2'd0;
        vld = |req;
        if (req[3])      idx = 2'd3;
        else if (req[2]) idx = 2'd2;
        else if (req[1]) idx = 2'd1;
    end
endmodule

// File: rtl/intc_core.sv
// Four-line interrupt controller: sticky status, fixed-priority arbitration, ISR address, W1C register window.
// Latency: done -> IRQ one cycle; IRQ/priority_select/isr_addr/read_data combinational from state.
// Backpressure: none; the optional MASK register is enabled by defining INTC_MASK_EN.
import intc_pkg::*;

module intc_core #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    done,
    input  logic          IACK,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] addr2,
    input  logic [DW-1:0] addr3,
    input  logic [AW-1:0] input_addr,
    input  logic [DW-1:0] write_data,
    input  logic          write_enable,
    output logic          IRQ,
    output logic [1:0]    priority_select,
    output logic [DW-1:0] isr_addr,
    output logic [DW-1:0] read_data
);
    logic [NUM_IRQ-1:0] stat;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] iack_clr;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] mask_rd;
    logic [1:0]         ofs;
    irq_idx_t           win_idx;
    logic               win_vld;

    assign ofs = input_addr[3:2];

    logic unused_bits;
    assign unused_bits = ^{input_addr[AW-1:4], input_addr[1:0], write_data[DW-1:4]};

`ifdef INTC_MASK_EN
    logic [NUM_IRQ-1:0] mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask <= 4'hF;
        else if (write_enable && ofs == MASK_OFS)
            mask <= write_data[3:0];
    end

    assign pend    = stat & mask;
    assign mask_rd = mask;
`else
    assign pend    = stat;
    assign mask_rd = 4'h0;
`endif

    intc_prio_enc u_prio_enc (
        .req (pend),
        .idx (win_idx),
        .vld (win_vld)
    );

    assign IRQ             = win_vld;
    assign priority_select = win_idx;

    always_comb begin
        isr_addr = addr0;
        case (win_idx)
            2'd1:    isr_addr = addr1;
            2'd2:    isr_addr = addr2;
            2'd3:    isr_addr = addr3;
            default: isr_addr = addr0;
        endcase
    end

    assign iack_clr = (IACK && win_vld) ? (4'b0001 << win_idx) : 4'b0000;
    assign w1c_clr  = (write_enable && ofs == STATUS_OFS) ? write_data[3:0] : 4'b0000;

    // New events are OR-ed in after clearing so a same-cycle set is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stat <= '0;
        else
            stat <= (stat & ~(iack_clr | w1c_clr)) | done;
    end

    always_comb begin
        read_data = '0;
        case (ofs)
            STATUS_OFS:  read_data = {{(DW-NUM_IRQ){1'b0}}, stat};
            PENDING_OFS: read_data = {{(DW-NUM_IRQ){1'b0}}, pend};
            MASK_OFS:    read_data = {{(DW-NUM_IRQ){1'b0}}, mask_rd};
            default:     read_data = '0;
        endcase
    end
endmodule

// File: tb/tb_intc_core.sv
// Directed bench for intc_core; honours INTC_MASK_EN when defined.
`timescale 1ns/1ps
module tb_intc_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  done = '0;
    logic        IACK = 1'b0;
    logic [31:0] addr0 = 32'h0A0, addr1 = 32'h100, addr2 = 32'h200, addr3 = 32'h300;
    logic [31:0] input_addr = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        IRQ;
    logic [1:0]  priority_select;
    logic [31:0] isr_addr;
    logic [31:0] read_data;

    int n_tests = 0;
    int n_fail  = 0;

    intc_core #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .done(done), .IACK(IACK),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .input_addr(input_addr), .write_data(write_data), .write_enable(write_enable),
        .IRQ(IRQ), .priority_select(priority_select), .isr_addr(isr_addr),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        input_addr = a;
        #1;
        d = read_data;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        input_addr   = a;
        write_data   = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        write_data   = '0;
    endtask

    task automatic iack();
        IACK = 1'b1;
        step();
        IACK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_irq", {31'b0, IRQ}, 32'd0);
        chk("rst_psel", {30'b0, priority_select}, 32'd0);
        chk("rst_isr", isr_addr, 32'h0A0);
        rd(32'h0, d); chk("rst_status", d, 32'h0);
        rd(32'h4, d); chk("rst_pending", d, 32'h0);

        // IACK with nothing pending has no effect
        iack();
        chk("idle_iack_irq", {31'b0, IRQ}, 32'd0);

        done = 4'b0010; step(); done = '0;
        chk("l1_irq", {31'b0, IRQ}, 32'd1);
        chk("l1_psel", {30'b0, priority_select}, 32'd1);
        chk("l1_isr", isr_addr, 32'h100);
        rd(32'h4, d); chk("l1_pending", d, 32'h2);
        iack();
        chk("l1_ack_irq", {31'b0, IRQ}, 32'd0);

        done = 4'b1001; step(); done = '0;
        chk("l30_psel", {30'b0, priority_select}, 32'd3);
        chk("l30_isr", isr_addr, 32'h300);
        iack();
        chk("l30_ack1_psel", {30'b0, priority_select}, 32'd0);
        chk("l30_ack1_isr", isr_addr, 32'h0A0);
        chk("l30_ack1_irq", {31'b0, IRQ}, 32'd1);
        iack();
        chk("l30_ack2_irq", {31'b0, IRQ}, 32'd0);

        done = 4'b0100; step(); done = '0;
        chk("l2_psel", {30'b0, priority_select}, 32'd2);
        done = 4'b0100; IACK = 1'b1; step(); done = '0; IACK = 1'b0;
        rd(32'h0, d); chk("l2_setwins_stat", d, 32'h4);
        chk("l2_setwins_irq", {31'b0, IRQ}, 32'd1);
        iack();
        chk("l2_ack_irq", {31'b0, IRQ}, 32'd0);

        done = 4'b0110; step(); done = '0;
        rd(32'h0, d); chk("w1c_pre", d, 32'h6);
        wr(32'h0, 32'hF);
        rd(32'h0, d); chk("w1c_stat", d, 32'h0);
        chk("w1c_irq", {31'b0, IRQ}, 32'd0);

        // Partial W1C plus a same-cycle set on a cleared line
        done = 4'b0101; step(); done = '0;
        done = 4'b0001; wr(32'h10, 32'h5); done = '0;
        rd(32'h0, d); chk("w1c_setwins", d, 32'h1);
        wr(32'h0, 32'hF);
        rd(32'hC, d); chk("ofs_c_read", d, 32'h0);

`ifdef INTC_MASK_EN
        rd(32'h8, d); chk("mask_rst", d, 32'hF);
        wr(32'h8, 32'h7);
        rd(32'h8, d); chk("mask_rd", d, 32'h7);
        done = 4'b1000; step(); done = '0;
        chk("mask_irq", {31'b0, IRQ}, 32'd0);
        rd(32'h0, d); chk("mask_status", d, 32'h8);
        rd(32'h4, d); chk("mask_pending", d, 32'h0);
        wr(32'h8, 32'hF);
        chk("unmask_psel", {30'b0, priority_select}, 32'd3);
        chk("unmask_irq", {31'b0, IRQ}, 32'd1);
`else
        wr(32'h8, 32'h7);
        rd(32'h8, d); chk("nomask_rd", d, 32'h0);
        done = 4'b1000; step(); done = '0;
        chk("nomask_irq", {31'b0, IRQ}, 32'd1);
`endif
        wr(32'h0, 32'hF);

        done = 4'b1111; step(); done = '0;
        rd(32'h0, d); chk("all_stat", d, 32'hF);
        chk("all_psel", {30'b0, priority_select}, 32'd3);
        #2;
        IACK = 1'b1;
        rst  = 1'b1;
        #1;
        chk("arst_irq", {31'b0, IRQ}, 32'd0);
        chk("arst_psel", {30'b0, priority_select}, 32'd0);
        chk("arst_isr", isr_addr, 32'h0A0);
        @(posedge clk);
        #1 rst = 1'b0; IACK = 1'b0;
        rd(32'h0, d); chk("arst_stat", d, 32'h0);
        step();
        chk("post_rst_irq", {31'b0, IRQ}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
